// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- central sequencing controller for the 5-stage MIPS32 pipeline.
//
// Merges per-stage stall requests into one priority-encoded hold vector,
// sequences multi-cycle divide stalls with a 6-bit countdown, and turns a
// committed exception / ERET into a one-cycle flush with a redirect PC.
//
// Ports:
//   Clk            in   1   system clock, rising edge
//   Rst            in   1   synchronous reset, active-high
//   Stall_Req_IF   in   1   instruction fetch not ready
//   Stall_Req_ID   in   1   load-use hazard in ID
//   Div_Start      in   1   EX issues a divide this cycle
//   Stall_Req_MEM  in   1   data memory wait
//   Excp_Valid     in   1   exception committed in MEM
//   Excp_Eret      in   1   qualifies Excp_Valid as ERET
//   CP0_EPC        in  32   ERET return address
//   Stall          out  6   hold per stage {WB,MEM,EX,ID,IF,PC}, 1 = hold
//   Flush          out  1   clear all pipeline registers, load New_PC
//   New_PC         out 32   redirect target, non-zero only while Flush = 1
//   Div_Done       out  1   divide result valid in EX (level)
//   Stall_Cnt      out 32   stall performance counter
//
// Build option:
//   PIPE_CTRL_PERF_EN  when defined, Stall_Cnt counts non-reset cycles with
//                      Stall[0] = 1 (saturating); otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter logic [31:0] EXC_VECTOR = 32'h00000020
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall_Req_IF,
    input  logic        Stall_Req_ID,
    input  logic        Div_Start,
    input  logic        Stall_Req_MEM,
    input  logic        Excp_Valid,
    input  logic        Excp_Eret,
    input  logic [31:0] CP0_EPC,
    output logic [5:0]  Stall,
    output logic        Flush,
    output logic [31:0] New_PC,
    output logic        Div_Done,
    output logic [31:0] Stall_Cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DIV   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // The cycle that sees Div_Start already stalls, so the countdown covers
    // the remaining DIV_CYCLES-1 cycles.
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 32'd1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [5:0]  cnt_r;
    logic [5:0]  cnt_nxt_s;
    logic [31:0] new_pc_r;
    logic [31:0] new_pc_nxt_s;
    logic        flush_r;
    logic        flush_nxt_s;
    logic [5:0]  stall_s;
    logic        div_busy_s;
    logic [31:0] exc_target_s;

    assign exc_target_s = Excp_Eret ? CP0_EPC : EXC_VECTOR;

    // Priority-encoded stall vector; FLUSH ignores every request.
    always_comb begin
        stall_s    = 6'b000000;
        div_busy_s = ((state_r == ST_RUN) && Div_Start) ||
                     ((state_r == ST_DIV) && (cnt_r != 6'd0));
        if (state_r == ST_FLUSH) begin
            stall_s = 6'b000000;
        end else if (Excp_Valid) begin
            stall_s = 6'b111111;
        end else if (Stall_Req_MEM) begin
            stall_s = 6'b011111;
        end else if (div_busy_s) begin
            stall_s = 6'b001111;
        end else if (Stall_Req_ID) begin
            stall_s = 6'b000111;
        end else if (Stall_Req_IF) begin
            stall_s = 6'b000011;
        end else begin
            stall_s = 6'b000000;
        end
    end

    // Next-state, countdown and redirect-capture logic.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        new_pc_nxt_s = new_pc_r;
        flush_nxt_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (Excp_Valid) begin
                    state_nxt_s  = ST_FLUSH;
                    new_pc_nxt_s = exc_target_s;
                    flush_nxt_s  = 1'b1;
                end else if (Div_Start) begin
                    state_nxt_s = ST_DIV;
                    cnt_nxt_s   = DIV_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DIV: begin
                if (Excp_Valid) begin
                    // Aborted divide: never reaches the cnt == 0 done window.
                    state_nxt_s  = ST_FLUSH;
                    cnt_nxt_s    = 6'd0;
                    new_pc_nxt_s = exc_target_s;
                    flush_nxt_s  = 1'b1;
                end else if (cnt_r != 6'd0) begin
                    cnt_nxt_s = cnt_r - 6'd1;
                end else if (!Stall_Req_MEM) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    // Result held (Div_Done high) until MEM lets EX move on.
                    state_nxt_s = ST_DIV;
                end
            end
            ST_FLUSH: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = 6'd0;
            end
        endcase
    end

    // State, countdown, redirect PC and flush registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r  <= ST_RUN;
            cnt_r    <= 6'd0;
            new_pc_r <= 32'h00000000;
            flush_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            new_pc_r <= new_pc_nxt_s;
            flush_r  <= flush_nxt_s;
        end
    end

    // Outputs are forced low while reset is asserted, even before the
    // synchronous reset has cleared the state registers.
    assign Stall    = Rst ? 6'b000000 : stall_s;
    assign Flush    = flush_r & ~Rst;
    assign New_PC   = Flush ? new_pc_r : 32'h00000000;
    assign Div_Done = ~Rst & (state_r == ST_DIV) & (cnt_r == 6'd0);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_r <= 32'h00000000;
        end else if (Stall[0] && (stall_cnt_r != 32'hFFFFFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign Stall_Cnt = stall_cnt_r;
`else
    assign Stall_Cnt = 32'h00000000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (DIV_CYCLES = 32).
// A table of single-cycle vectors covers the stall priority encoder and the
// exception/ERET flush path; hand-written sequences cover divide timing,
// MEM stalls around divide completion, aborted divides and reset mid-FLUSH.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic        Clk;
    logic        Rst;
    logic        Stall_Req_IF;
    logic        Stall_Req_ID;
    logic        Div_Start;
    logic        Stall_Req_MEM;
    logic        Excp_Valid;
    logic        Excp_Eret;
    logic [31:0] CP0_EPC;
    logic [5:0]  Stall;
    logic        Flush;
    logic [31:0] New_PC;
    logic        Div_Done;
    logic [31:0] Stall_Cnt;

    int          errors;
    int          checks;
    int          exp_cnt;
    int          done_rises;
    logic        prev_done;

    pipe_ctrl #(
        .DIV_CYCLES (32),
        .EXC_VECTOR (32'h00000020)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .Stall_Req_IF  (Stall_Req_IF),
        .Stall_Req_ID  (Stall_Req_ID),
        .Div_Start     (Div_Start),
        .Stall_Req_MEM (Stall_Req_MEM),
        .Excp_Valid    (Excp_Valid),
        .Excp_Eret     (Excp_Eret),
        .CP0_EPC       (CP0_EPC),
        .Stall         (Stall),
        .Flush         (Flush),
        .New_PC        (New_PC),
        .Div_Done      (Div_Done),
        .Stall_Cnt     (Stall_Cnt)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        s_if;
        logic        s_id;
        logic        ds;
        logic        mem;
        logic        ex;
        logic        er;
        logic [31:0] epc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_done;
    } vec_t;

    vec_t vec [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic clr();
        Stall_Req_IF  = 1'b0;
        Stall_Req_ID  = 1'b0;
        Div_Start     = 1'b0;
        Stall_Req_MEM = 1'b0;
        Excp_Valid    = 1'b0;
        Excp_Eret     = 1'b0;
        CP0_EPC       = 32'h00000000;
    endtask

    // Inputs for the current cycle are already applied; check outputs, update
    // the stall-counter model, then advance to just after the next posedge.
    task automatic tick(input string nm, input logic [5:0] es, input logic ef,
                        input logic [31:0] epc_e, input logic ed, input logic ed_dc);
        #2;
        chk({nm, "/stall"}, 32'(Stall), 32'(es));
        chk({nm, "/flush"}, 32'(Flush), 32'(ef));
        chk({nm, "/new_pc"}, New_PC, epc_e);
        if (!ed_dc) begin
            chk({nm, "/div_done"}, 32'(Div_Done), 32'(ed));
        end
`ifdef PIPE_CTRL_PERF_EN
        chk({nm, "/stall_cnt"}, Stall_Cnt, 32'(exp_cnt));
`else
        chk({nm, "/stall_cnt"}, Stall_Cnt, 32'h00000000);
`endif
        if (Div_Done && !prev_done) begin
            done_rises++;
        end
        prev_done = Div_Done;
        if (Rst) begin
            exp_cnt = 0;
        end else if (es[0]) begin
            exp_cnt++;
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        exp_cnt    = 0;
        done_rises = 0;
        prev_done  = 1'b0;
        clr();
        Rst = 1'b1;

        //            if    id    ds    mem   ex    er    epc           stall      fl    new_pc        done
        vec[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b000000, 1'b0, 32'h00000000, 1'b0};
        vec[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b000000, 1'b0, 32'h00000000, 1'b0};
        vec[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b000000, 1'b0, 32'h00000000, 1'b0};
        vec[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b000000, 1'b0, 32'h00000000, 1'b0};
        vec[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b000000, 1'b0, 32'h00000000, 1'b0};
        vec[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b000111, 1'b0, 32'h00000000, 1'b0};
        vec[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b000000, 1'b0, 32'h00000000, 1'b0};
        vec[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 6'b011111, 1'b0, 32'h00000000, 1'b0};
        vec[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b000011, 1'b0, 32'h00000000, 1'b0};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b000111, 1'b0, 32'h00000000, 1'b0};
        vec[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 6'b011111, 1'b0, 32'h00000000, 1'b0};
        // exception beats a simultaneous divide
        vec[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, 6'b111111, 1'b0, 32'h00000000, 1'b0};
        // FLUSH cycle: everything driven is ignored
        vec[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 6'b000000, 1'b1, 32'h00000020, 1'b0};
        // back-to-back ERET right after FLUSH
        vec[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBFC00104, 6'b111111, 1'b0, 32'h00000000, 1'b0};
        vec[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b000000, 1'b1, 32'hBFC00104, 1'b0};
        vec[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b000000, 1'b0, 32'h00000000, 1'b0};
        // divide accepted under a MEM stall, then divide outranks ID
        vec[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00000000, 6'b011111, 1'b0, 32'h00000000, 1'b0};
        vec[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 6'b001111, 1'b0, 32'h00000000, 1'b0};

        @(posedge Clk);
        #1;
        tick("reset0", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        Rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            Stall_Req_IF  = vec[i].s_if;
            Stall_Req_ID  = vec[i].s_id;
            Div_Start     = vec[i].ds;
            Stall_Req_MEM = vec[i].mem;
            Excp_Valid    = vec[i].ex;
            Excp_Eret     = vec[i].er;
            CP0_EPC       = vec[i].epc;
            tick($sformatf("vec%0d", i), vec[i].e_stall, vec[i].e_flush, vec[i].e_pc,
                 vec[i].e_done, 1'b0);
        end

        // Reset while a divide is in progress: outputs zero, then plain RUN.
        clr();
        Stall_Req_ID = 1'b1;
        Rst = 1'b1;
        tick("rst_div", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        Rst = 1'b0;
        tick("rst_div_run", 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0);

        // Divide timing: EX held for 32 cycles, done in the 33rd, RUN after.
        clr();
        Div_Start = 1'b1;
        tick("divA_start", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k < 32; k++) begin
            clr();
            Div_Start    = (k == 5);
            Stall_Req_ID = (k == 20);
            tick($sformatf("divA_%0d", k), 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
        end
        clr();
        tick("divA_done", 6'b000000, 1'b0, 32'h0, 1'b1, 1'b0);
        Stall_Req_ID = 1'b1;
        tick("divA_run", 6'b000111, 1'b0, 32'h0, 1'b0, 1'b0);

        // Divide completing under a MEM stall: one held completion.
        clr();
        done_rises = 0;
        Div_Start  = 1'b1;
        tick("divB_start", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k < 37; k++) begin
            clr();
            Stall_Req_MEM = (k >= 30) && (k <= 34);
            if (k < 30) begin
                tick($sformatf("divB_%0d", k), 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
            end else if (k <= 34) begin
                tick($sformatf("divB_%0d", k), 6'b011111, 1'b0, 32'h0, (k >= 32), 1'b0);
            end else begin
                tick($sformatf("divB_%0d", k), 6'b000000, 1'b0, 32'h0, 1'b0, (k == 35));
            end
        end
        chk("divB_completions", 32'(done_rises), 32'd1);

        // Exception mid-divide aborts it; no completion ever appears.
        clr();
        done_rises = 0;
        Div_Start  = 1'b1;
        tick("divC_start", 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int k = 1; k < 46; k++) begin
            clr();
            if (k < 10) begin
                tick($sformatf("divC_%0d", k), 6'b001111, 1'b0, 32'h0, 1'b0, 1'b0);
            end else if (k == 10) begin
                Excp_Valid = 1'b1;
                CP0_EPC    = 32'hCAFEF00D;
                tick("divC_excp", 6'b111111, 1'b0, 32'h0, 1'b0, 1'b0);
            end else if (k == 11) begin
                tick("divC_flush", 6'b000000, 1'b1, 32'h00000020, 1'b0, 1'b0);
            end else begin
                tick($sformatf("divC_%0d", k), 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
            end
        end
        chk("divC_completions", 32'(done_rises), 32'd0);

        // ERET, reset during the FLUSH cycle, then the same ERET without reset.
        clr();
        Excp_Valid = 1'b1;
        Excp_Eret  = 1'b1;
        CP0_EPC    = 32'hBFC00104;
        tick("eretD_excp", 6'b111111, 1'b0, 32'h0, 1'b0, 1'b0);
        clr();
        Rst = 1'b1;
        tick("eretD_rst", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        Rst = 1'b0;
        tick("eretD_after_rst", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        Excp_Valid = 1'b1;
        Excp_Eret  = 1'b1;
        CP0_EPC    = 32'hBFC00104;
        tick("eretE_excp", 6'b111111, 1'b0, 32'h0, 1'b0, 1'b0);
        clr();
        tick("eretE_flush", 6'b000000, 1'b1, 32'hBFC00104, 1'b0, 1'b0);
        tick("eretE_idle", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        Stall_Req_IF = 1'b1;
        tick("eretE_if", 6'b000011, 1'b0, 32'h0, 1'b0, 1'b0);
        clr();
        tick("final", 6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
